// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-fetch interface between the multicycle ARM
// controller and instruction memory. Issues one read per fetch request over a
// variable-latency req/ack handshake, latches the returned word into Instr and
// stalls the controller until it arrives. Misaligned PCs and memory timeouts
// drive a sticky fault and park the block in ERR until reset.
// Optional feature: define FETCH_STATS_EN to add the saturating fetch_count
// output (completed fetches since reset).
module instr_fetch_if #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] Instr,
    output logic              instr_valid,
    output logic              stall,
    output logic              fault
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    // Word returned to the controller on a timeout: MOV r0, r0
    localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'hE1A00000);
    // Last counter value allowed in WAIT before the timeout fires
    localparam logic [7:0]        TO_LAST  = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              fault_q, fault_d;
    logic [7:0]        cnt_q, cnt_d;
`ifdef FETCH_STATS_EN
    logic [15:0]       fcnt_q, fcnt_d;
`endif

    // State and output registers, cleared by the active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
`ifdef FETCH_STATS_EN
            fcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
`ifdef FETCH_STATS_EN
            fcnt_q     <= fcnt_d;
`endif
        end
    end

    // Next-state logic: defaults hold everything except the valid pulse
    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        instr_d    = instr_q;
        valid_d    = 1'b0;
        fault_d    = fault_q;
        cnt_d      = cnt_q;
`ifdef FETCH_STATS_EN
        fcnt_d     = fcnt_q;
`endif
        case (state_q)
            IDLE: begin
                // mem_ack is ignored here; only a fetch request moves us on
                if (fetch_req) begin
                    if (pc[1:0] == 2'b00) begin
                        mem_addr_d = pc;
                        mem_req_d  = 1'b1;
                        cnt_d      = '0;
                        state_d    = WAIT;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                // Ack takes priority over a timeout landing on the same edge
                if (mem_ack) begin
                    instr_d   = mem_rdata;
                    valid_d   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
`ifdef FETCH_STATS_EN
                    if (fcnt_q != 16'hFFFF) begin
                        fcnt_d = fcnt_q + 16'd1;
                    end
`endif
                end else if (cnt_q == TO_LAST) begin
                    mem_req_d = 1'b0;
                    fault_d   = 1'b1;
                    instr_d   = NOP_WORD;
                    state_d   = ERR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ERR: begin
                // Absorbing until reset; mem_req already low
                mem_req_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller stall: combinational so a fetch request is held the same cycle
    always_comb begin
        stall = (state_q != IDLE) || fetch_req;
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign Instr       = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
`ifdef FETCH_STATS_EN
    assign fetch_count = fcnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_if.sv
// Self-checking bench for instr_fetch_if: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch interface.
module tb_instr_fetch_if;

    localparam int TIMEOUT = 15;
    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] Instr;
    logic        instr_valid;
    logic        stall;
    logic        fault;
`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    instr_fetch_if #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_req  (fetch_req),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .Instr      (Instr),
        .instr_valid(instr_valid),
        .stall      (stall),
        .fault      (fault)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Transaction-level model: is a read outstanding, how many cycles it has
    // gone unanswered, has the block faulted, and what the outputs should show.
    bit          m_busy;
    bit          m_dead;
    int          m_waited;
    logic        m_req;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    int          m_count;

    task automatic model_clear();
        m_busy = 0; m_dead = 0; m_waited = 0;
        m_req = 0; m_addr = 0; m_instr = 0; m_valid = 0; m_fault = 0; m_count = 0;
    endtask

    // Apply the inputs present at this clock edge to the model
    task automatic model_update();
        if (!reset) begin
            model_clear();
        end else begin
            m_valid = 0;
            if (m_dead) begin
                m_req = 0;
            end else if (m_busy) begin
                if (mem_ack) begin
                    m_instr = mem_rdata;
                    m_valid = 1;
                    m_req   = 0;
                    m_busy  = 0;
                    if (m_count < 65535) m_count++;
                end else if (m_waited + 1 >= TIMEOUT) begin
                    m_req   = 0;
                    m_fault = 1;
                    m_instr = NOP;
                    m_busy  = 0;
                    m_dead  = 1;
                end else begin
                    m_waited++;
                end
            end else if (fetch_req) begin
                if (pc % 4 == 0) begin
                    m_req = 1; m_addr = pc; m_busy = 1; m_waited = 0;
                end else begin
                    m_fault = 1; m_dead = 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare all outputs against the model, advance
    task automatic step(input logic r, input logic fr, input logic [31:0] p,
                        input logic ak, input logic [31:0] rd);
        reset = r; fetch_req = fr; pc = p; mem_ack = ak; mem_rdata = rd;
        #1;
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        chk("mem_addr", mem_addr, m_addr);
        chk("Instr", Instr, m_instr);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("stall", {31'd0, stall}, {31'd0, (m_busy || m_dead || fr)});
`ifdef FETCH_STATS_EN
        chk("fetch_count", {16'd0, fetch_count}, 32'(m_count));
`endif
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Complete fetch with the ack arriving on the lat-th mem_req cycle
    task automatic fetch_ok(input logic [31:0] p, input int lat, input logic [31:0] rd);
        step(1, 1, p, 0, 0);
        for (int i = 1; i < lat; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, rd);
    endtask

    initial begin
        int reqcnt;
        reset = 0; fetch_req = 0; pc = 0; mem_ack = 0; mem_rdata = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_fault", {31'd0, fault}, 32'd0);

        // Basic fetch: ack on first mem_req cycle
        step(1, 1, 32'h0, 0, 0);
        chk("basic_req", {31'd0, mem_req}, 32'd1);
        chk("basic_addr", mem_addr, 32'h0);
        step(1, 0, 0, 1, 32'hE04F000F);
        chk("basic_valid", {31'd0, instr_valid}, 32'd1);
        chk("basic_instr", Instr, 32'hE04F000F);
        step(1, 0, 0, 0, 0);
        chk("basic_valid_drop", {31'd0, instr_valid}, 32'd0);

        // Variable latency: 5 cycles
        fetch_ok(32'h8, 5, 32'hE2802005);
        chk("lat5_instr", Instr, 32'hE2802005);
        chk("lat5_fault", {31'd0, fault}, 32'd0);

        // Ack on the timeout cycle, then back-to-back fetch on the valid cycle
        fetch_ok(32'h20, TIMEOUT, 32'hE3A01001);
        chk("collide_fault", {31'd0, fault}, 32'd0);
        chk("collide_instr", Instr, 32'hE3A01001);
        step(1, 1, 32'hC, 0, 0);
        chk("b2b_req", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr", mem_addr, 32'hC);
        step(1, 0, 0, 1, 32'hE0811002);
        step(1, 0, 0, 1, 32'hDEADBEEF);
        chk("spurious_instr", Instr, 32'hE0811002);

        // Timeout: count mem_req high cycles
        step(1, 1, 32'h10, 0, 0);
        reqcnt = mem_req ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 0);
            if (mem_req) reqcnt++;
        end
        chk("to_reqcycles", 32'(reqcnt), 32'd15);
        chk("to_fault", {31'd0, fault}, 32'd1);
        chk("to_instr", Instr, NOP);
        step(1, 1, 32'h4, 0, 0);
        chk("err_ignores_fetch", {31'd0, mem_req}, 32'd0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Misaligned PC
        step(1, 1, 32'h6, 0, 0);
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_req", {31'd0, mem_req}, 32'd0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Statistics: 3 good fetches and a timeout, then reset mid-WAIT
        fetch_ok(32'h40, 1, 32'h1);
        fetch_ok(32'h44, 3, 32'h2);
        fetch_ok(32'h48, 2, 32'h3);
        step(1, 1, 32'h4C, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(1, 0, 0, 0, 0);
`ifdef FETCH_STATS_EN
        chk("stats_count", {16'd0, fetch_count}, 32'd3);
`endif
        step(0, 0, 0, 0, 0);
        step(1, 1, 32'h50, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h5555AAAA);
        step(1, 0, 0, 0, 0);
        chk("late_ack_instr", Instr, 32'h0);
`ifdef FETCH_STATS_EN
        chk("stats_after_rst", {16'd0, fetch_count}, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic        r, fr, ak;
            logic [31:0] p;
            r  = !(m_dead ? ($urandom_range(3) == 0) : ($urandom_range(199) == 0));
            fr = ($urandom_range(2) == 0);
            p  = {$urandom_range(32'h0000FFFF), 2'b00};
            if ($urandom_range(39) == 0) p[1:0] = 2'($urandom_range(1, 3));
            if (m_busy) ak = ($urandom_range(9) < 2);
            else        ak = ($urandom_range(9) == 0);
            step(r, fr, p, ak, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
